// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - responder register bank on the shared executor memory bus.
// Optional MEMORY_BANK_ZERO_CELL_EN: cell 0 hardwired to zero and writes to it ignored.
module memory_bank #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [M-1:0]      MemorySelect,
  inout  wire  [N-1:0]      MemoryData,
  input  logic              MemoryRW,
  input  logic              DirtyClear,
  output logic [2**M-1:0]   Dirty,
  output logic [15:0]       WriteCount,
  output logic [M-1:0]      LastSelect,
  input  logic [M-1:0]      DebugSelect,
  output logic [N-1:0]      DebugData
);

  localparam int CELLS = 2**M;

  logic [N-1:0]     cells_q [CELLS];
  logic [N-1:0]     cells_d [CELLS];
  logic [CELLS-1:0] dirty_q, dirty_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [M-1:0]     last_q, last_d;
  logic             write_accept;
  logic [N-1:0]     bus_rd_data;

`ifdef MEMORY_BANK_ZERO_CELL_EN
  assign write_accept = MemoryRW && (MemorySelect != '0);
  assign bus_rd_data  = (MemorySelect == '0) ? '0 : cells_q[MemorySelect];
  assign DebugData    = (DebugSelect  == '0) ? '0 : cells_q[DebugSelect];
`else
  assign write_accept = MemoryRW;
  assign bus_rd_data  = cells_q[MemorySelect];
  assign DebugData    = cells_q[DebugSelect];
`endif

  // The bank only drives the bus while the initiator is reading.
  assign MemoryData = MemoryRW ? {N{1'bz}} : bus_rd_data;

  always_comb begin
    cells_d = cells_q;
    dirty_d = dirty_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    if (DirtyClear) begin
      dirty_d = '0;
    end
    // Applied after the clear so a same-edge write keeps its dirty bit.
    if (write_accept) begin
      cells_d[MemorySelect] = MemoryData;
      dirty_d[MemorySelect] = 1'b1;
      wcnt_d                = wcnt_q + 16'd1;
      last_d                = MemorySelect;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < CELLS; i++) begin
        cells_q[i] <= '0;
      end
      dirty_q <= '0;
      wcnt_q  <= '0;
      last_q  <= '0;
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        cells_q[i] <= cells_d[i];
      end
      dirty_q <= dirty_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
    end
  end

  assign Dirty      = dirty_q;
  assign WriteCount = wcnt_q;
  assign LastSelect = last_q;

endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - directed self-checking bench for memory_bank.
module tb_memory_bank;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [1:0]  MemorySelect;
  wire  [7:0]  MemoryData;
  logic        MemoryRW;
  logic        DirtyClear;
  logic [3:0]  Dirty;
  logic [15:0] WriteCount;
  logic [1:0]  LastSelect;
  logic [1:0]  DebugSelect;
  logic [7:0]  DebugData;

  logic [7:0]  drv_data;
  logic        drv_en;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_wc;

  assign MemoryData = drv_en ? drv_data : 8'bz;

  always #5 Clock = ~Clock;

  memory_bank #(.N(8), .M(2)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .MemorySelect (MemorySelect),
    .MemoryData   (MemoryData),
    .MemoryRW     (MemoryRW),
    .DirtyClear   (DirtyClear),
    .Dirty        (Dirty),
    .WriteCount   (WriteCount),
    .LastSelect   (LastSelect),
    .DebugSelect  (DebugSelect),
    .DebugData    (DebugData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] data, input logic clr);
    MemorySelect = sel;
    MemoryRW     = 1'b1;
    drv_data     = data;
    drv_en       = 1'b1;
    DirtyClear   = clr;
    tick();
    MemoryRW   = 1'b0;
    drv_en     = 1'b0;
    DirtyClear = 1'b0;
    #1;
  endtask

  initial begin
    ResetN       = 1'b0;
    MemorySelect = 2'd0;
    MemoryRW     = 1'b0;
    DirtyClear   = 1'b0;
    DebugSelect  = 2'd0;
    drv_data     = 8'h00;
    drv_en       = 1'b0;
    exp_wc       = 16'd0;

    #3;
    for (int i = 0; i < 4; i++) begin
      MemorySelect = 2'(i);
      #1;
      check($sformatf("reset_bus_%0d", i), 32'(MemoryData), 32'h00);
    end
    check("reset_dirty", 32'(Dirty), 32'h0);
    check("reset_wcnt", 32'(WriteCount), 32'h0);
    check("reset_last", 32'(LastSelect), 32'h0);
    tick();
    ResetN = 1'b1;
    tick();

    // Write 5A to cell 2, read it back on the bus
    MemorySelect = 2'd2;
    MemoryRW     = 1'b1;
    drv_data     = 8'h5A;
    drv_en       = 1'b1;
    #1;
    check("wr_no_contention", 32'(MemoryData), 32'h5A);
    tick();
    MemoryRW = 1'b0;
    drv_en   = 1'b0;
    #1;
    exp_wc = 16'd1;
    check("rd_cell2", 32'(MemoryData), 32'h5A);
    check("dirty_after_wr2", 32'(Dirty), 32'b0100);
    check("last_after_wr2", 32'(LastSelect), 32'd2);
    check("wcnt_after_wr2", 32'(WriteCount), 32'(exp_wc));

    // Cell 0 write, then cell 1 write with DirtyClear on the same edge
    bus_write(2'd0, 8'h11, 1'b0);
`ifdef MEMORY_BANK_ZERO_CELL_EN
    check("dirty_0101", 32'(Dirty), 32'b0100);
`else
    exp_wc = exp_wc + 16'd1;
    check("dirty_0101", 32'(Dirty), 32'b0101);
`endif
    bus_write(2'd1, 8'h22, 1'b1);
    exp_wc = exp_wc + 16'd1;
    check("dirty_clear_vs_wr", 32'(Dirty), 32'b0010);
    check("wcnt_after_clr_wr", 32'(WriteCount), 32'(exp_wc));
    DebugSelect = 2'd1;
    #1;
    check("dbg_cell1", 32'(DebugData), 32'h22);
    DebugSelect = 2'd0;
    #1;
`ifdef MEMORY_BANK_ZERO_CELL_EN
    check("dbg_cell0", 32'(DebugData), 32'h00);
`else
    check("dbg_cell0", 32'(DebugData), 32'h11);
`endif

    DirtyClear = 1'b1;
    tick();
    DirtyClear = 1'b0;
    check("dirty_clear_only", 32'(Dirty), 32'b0000);
    check("wcnt_clear_only", 32'(WriteCount), 32'(exp_wc));

    // Back-to-back writes to cell 3; same-edge read select sees new data
    MemorySelect = 2'd3;
    MemoryRW     = 1'b1;
    drv_en       = 1'b1;
    drv_data     = 8'hA1;
    tick();
    drv_data     = 8'hB2;
    tick();
    MemoryRW = 1'b0;
    drv_en   = 1'b0;
    #1;
    exp_wc = exp_wc + 16'd2;
    check("b2b_data", 32'(MemoryData), 32'hB2);
    check("b2b_wcnt", 32'(WriteCount), 32'(exp_wc));
    check("b2b_last", 32'(LastSelect), 32'd3);

    // Counter wrap: hold a write until the counter reaches FFFF, then one more
    MemorySelect = 2'd3;
    MemoryRW     = 1'b1;
    drv_en       = 1'b1;
    drv_data     = 8'h3C;
    for (int i = int'(exp_wc); i < 65535; i++) begin
      @(posedge Clock);
    end
    #1;
    check("wcnt_ffff", 32'(WriteCount), 32'hFFFF);
    tick();
    check("wcnt_wrap", 32'(WriteCount), 32'h0000);

    // Async reset mid-write
    MemorySelect = 2'd2;
    drv_data     = 8'h77;
    DebugSelect  = 2'd2;
    #1;
    check("dbg_cell2_pre_rst", 32'(DebugData), 32'h5A);
    #1;
    ResetN = 1'b0;
    #1;
    check("rst_mid_dbg2", 32'(DebugData), 32'h00);
    check("rst_mid_dirty", 32'(Dirty), 32'h0);
    check("rst_mid_wcnt", 32'(WriteCount), 32'h0);
    check("rst_mid_last", 32'(LastSelect), 32'h0);
    tick();
    MemoryRW = 1'b0;
    drv_en   = 1'b0;
    #1;
    check("rst_mid_bus2", 32'(MemoryData), 32'h00);
    ResetN = 1'b1;
    tick();
    check("post_rst_wcnt", 32'(WriteCount), 32'h0);
    exp_wc = 16'd0;

    // Cell 0 and cell 3 with FF
    bus_write(2'd0, 8'hFF, 1'b0);
    MemorySelect = 2'd0;
    #1;
`ifdef MEMORY_BANK_ZERO_CELL_EN
    check("zc_bus0", 32'(MemoryData), 32'h00);
    check("zc_dirty0", 32'(Dirty[0]), 32'd0);
    check("zc_wcnt", 32'(WriteCount), 32'(exp_wc));
    check("zc_last", 32'(LastSelect), 32'd0);
`else
    exp_wc = exp_wc + 16'd1;
    check("zc_bus0", 32'(MemoryData), 32'hFF);
    check("zc_dirty0", 32'(Dirty[0]), 32'd1);
    check("zc_wcnt", 32'(WriteCount), 32'(exp_wc));
`endif
    bus_write(2'd3, 8'hFF, 1'b0);
    exp_wc = exp_wc + 16'd1;
    MemorySelect = 2'd3;
    #1;
    check("zc_bus3", 32'(MemoryData), 32'hFF);
    check("zc_wcnt3", 32'(WriteCount), 32'(exp_wc));
    check("zc_last3", 32'(LastSelect), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_bank.md
# memory_bank

Responder side of the executor memory bus: a bank of 2^M cells, N bits each, that serves reads and captures writes issued over the shared `MemorySelect` / `MemoryData` / `MemoryRW` bus. It sits opposite the instruction executor and acts as its register file. It also keeps per-cell dirty flags, a write counter, and the last-written address for debug and test.

## Interface
Parameters:
- `N`, 8, cell width in bits (also the data bus width).
- `M`, 2, select bus width; cell count is 2^M.

Ports:
- `Clock`  input  1  posedge clock.
- `ResetN`  input  1  asynchronous, active-low reset.
- `MemorySelect`  input  M  binary cell index.
- `MemoryData`  inout  N  shared data bus.
- `MemoryRW`  input  1  0 = read (bank drives bus), 1 = write (initiator drives bus).
- `DirtyClear`  input  1  synchronous clear of all dirty flags.
- `Dirty`  output  2^M  per-cell "written since last clear" flags.
- `WriteCount`  output  16  number of accepted writes, wraps.
- `LastSelect`  output  M  index of the most recently accepted write.
- `DebugSelect`  input  M  side-band read index.
- `DebugData`  output  N  contents of cell `DebugSelect`.

## Operation
- Storage is a 2^M x N register array. Reset clears every cell to 0.
- **Read path:**
  - When `MemoryRW`=0, `MemoryData` is driven combinationally with `cell[MemorySelect]`.
  - When `MemoryRW`=1, the bank tri-states `MemoryData` to `{N{1'bz}}`.
  - The read path is active during reset. With all cells at 0, the bank drives 0.
- **Write path:** on posedge `Clock` with `ResetN`=1 and `MemoryRW`=1, the bank performs all of the following on the same edge:
  - `cell[MemorySelect] <= MemoryData`.
  - `Dirty[MemorySelect] <= 1`.
  - `LastSelect <= MemorySelect`.
  - `WriteCount <= WriteCount + 1`, mod 2^16; 16'hFFFF wraps to 0.
- **Dirty clear:**
  - On posedge with `DirtyClear`=1, all `Dirty` bits clear.
  - If a write is accepted on the same edge, the written cell's bit is set and all other bits clear. The write wins.
- **Debug port:** `DebugData = cell[DebugSelect]` combinationally. It is independent of bus state and has no side effects.
- **Back-to-back writes:** a write to the same cell on consecutive edges keeps the last value. Each write increments `WriteCount`.
- **No protocol FSM:** the bank is a pure responder. Every edge with `MemoryRW`=1 is one write.
- **Unknown bus value:** X or Z on `MemoryData` during a write is stored as-is. Avoiding this is the initiator's responsibility.

## Timing
- Read latency is 0 cycles.
  - Data is valid once `MemorySelect` settles after the edge on which the initiator updates it.
  - The initiator therefore samples read data on the following edge.
- A write is captured on the edge that ends the cycle in which `MemoryRW`=1.
  - Data written at edge k is readable combinationally right after edge k.
  - A write at edge k and a read select issued at edge k: the read returns the new value.
- Reset (asynchronous, `ResetN`=0) immediately sets:
  - all cells = 0, `Dirty` = 0, `WriteCount` = 0, `LastSelect` = 0;
  - `DebugData` = 0;
  - `MemoryData` = 0 if `MemoryRW`=0, otherwise Z.
- Reset asserted mid-write: the write is discarded. Releasing `ResetN` takes effect for edges after the deassertion.

## Configuration
- Macro `MEMORY_BANK_ZERO_CELL_EN`.
- Defined:
  - Cell 0 is hardwired to 0; reads on the bus and the debug port return 0.
  - Writes with `MemorySelect`=0 are ignored entirely: no data change, no `Dirty[0]` set, no `WriteCount` increment, no `LastSelect` update.
  - The bus is still tri-stated during such a write.
- Undefined: cell 0 is an ordinary storage cell.

## Test plan
- **Reset:** pulse `ResetN` low, then hold `MemoryRW`=0 and sweep `MemorySelect` 0..3 -> `MemoryData`=0 for every index, `Dirty`=4'b0000, `WriteCount`=0.
- **Write then read:** drive 8'h5A on the bus with `MemoryRW`=1, `MemorySelect`=2 for one edge, then set `MemoryRW`=0, `MemorySelect`=2 -> bank drives 8'h5A, `Dirty`=4'b0100, `LastSelect`=2, `WriteCount`=1. While the initiator drives, the bank is Z (no contention).
- **Dirty clear vs. write:** write cell 1 with `DirtyClear`=1 on the same edge, with `Dirty` previously 4'b0101 -> `Dirty`=4'b0010.
- **Counter wrap:** preload via 65535 writes, then do one more write -> `WriteCount`=0.
- **Async reset mid-write:** assert `ResetN` low between edges while `MemoryRW`=1 -> all state is 0 at once and the write is lost. `DebugSelect`=2 gives `DebugData`=0.
- **With `MEMORY_BANK_ZERO_CELL_EN`:** write 8'hFF to cell 0 -> bus read of cell 0 = 0, `Dirty[0]`=0, `WriteCount` unchanged. A write of 8'hFF to cell 3 still reads back 8'hFF.
